plic_lite: RTL and testbench

Platform-level interrupt arbiter that collects NUM_SOURCES level-sensitive device interrupt lines, gates them, and arbitrates by priority. It drives the single external_interrupt input of the CSR unit (MEIP). The core talks to it over a memory-mapped register port with a request/ack handshake, and uses claim/complete to take and retire interrupts. Source ID 0 is reserved and means "no interrupt".

---
 rtl/plic_lite.sv | 188 ++++++++++++++++++
 tb/tb_plic_lite.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plic_lite.sv
// plic_lite: platform-level interrupt arbiter.
// Collects level interrupt lines, latches them through a per-source gateway,
// picks the highest-priority enabled source above threshold and drives MEIP.
// Register port: request held until a one-cycle ack (IDLE -> ACK -> IDLE).
// A request is accepted only in IDLE; the requester must drop its enable
// in the ACK cycle, and bus_rd_data is nonzero only while bus_ack is high.
module plic_lite #(
  parameter int NUM_SOURCES = 8,
  parameter int PRIO_WIDTH  = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  input  logic                   bus_rd_en,
  input  logic                   bus_wr_en,
  input  logic [7:0]             bus_addr,
  input  logic [DATA_SIZE-1:0]   bus_wr_data,
  output logic [DATA_SIZE-1:0]   bus_rd_data,
  output logic                   bus_ack,
  output logic                   external_interrupt
);

  localparam int IDW = 5;

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  // Per-source vectors are indexed by source ID; ID 0 has no storage.
  logic [NUM_SOURCES:1]    r_sync1;
  logic [NUM_SOURCES:1]    r_sync2;
  logic [NUM_SOURCES:1]    r_pending;
  logic [NUM_SOURCES:1]    r_in_flight;
  logic [NUM_SOURCES:1]    r_enable;
  logic [PRIO_WIDTH-1:0]   r_prio [1:NUM_SOURCES];
  logic [PRIO_WIDTH-1:0]   r_threshold;
  logic                    r_ext;
  logic [DATA_SIZE-1:0]    r_rd_data;

  logic                    w_req;
  logic                    w_do_wr;
  logic                    w_do_rd;
  logic                    w_is_prio;
  logic [4:0]              w_word;
  logic                    w_sel_pend;
  logic                    w_sel_en;
  logic                    w_sel_thr;
  logic                    w_sel_claim;
  logic [IDW-1:0]          w_best_id;
  logic [PRIO_WIDTH-1:0]   w_best_prio;
  logic [DATA_SIZE-1:0]    w_rd_val;
  logic                    w_claim;
  logic                    w_complete;
  logic [IDW-1:0]          w_cid;
  logic                    w_unused;

  // Address decode: below 0x80 is the priority array, 0x80..0x8C the control words.
  assign w_is_prio   = ~bus_addr[7];
  assign w_word      = bus_addr[6:2];
  assign w_sel_pend  = (bus_addr[7:2] == 6'h20);
  assign w_sel_en    = (bus_addr[7:2] == 6'h21);
  assign w_sel_thr   = (bus_addr[7:2] == 6'h22);
  assign w_sel_claim = (bus_addr[7:2] == 6'h23);
  assign w_cid       = bus_wr_data[IDW-1:0];
  assign w_unused    = &{1'b0, bus_addr[1:0], bus_wr_data};

  // A claim only has side effects when it actually hands out a source.
  assign w_claim     = w_do_rd && w_sel_claim && (w_best_id != '0);
  assign w_complete  = w_do_wr && w_sel_claim;

  assign bus_rd_data        = r_rd_data;
  assign external_interrupt = r_ext;

  // Bus FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Bus FSM next state: any request in IDLE goes to ACK, ACK always returns.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus_rd_en || bus_wr_en) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus FSM outputs: accept in IDLE only; a simultaneous rd/wr is a write.
  always_comb begin
    bus_ack = (r_state == S_ACK);
    w_req   = (r_state == S_IDLE) && (bus_rd_en || bus_wr_en);
    w_do_wr = w_req && bus_wr_en;
    w_do_rd = w_req && bus_rd_en && !bus_wr_en;
  end

  // Arbiter: strictly higher priority wins, so scanning upward keeps the lowest ID on ties.
  always_comb begin
    w_best_id   = '0;
    w_best_prio = '0;
    for (int i = 1; i <= NUM_SOURCES; i++) begin
      if (r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold) &&
          (r_prio[i] > w_best_prio)) begin
        w_best_id   = IDW'(i);
        w_best_prio = r_prio[i];
      end
    end
  end

  // Read mux for the register map; unmapped words and ID 0 read zero.
  always_comb begin
    w_rd_val = '0;
    if (w_is_prio) begin
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        if (int'(w_word) == i) w_rd_val[PRIO_WIDTH-1:0] = r_prio[i];
      end
    end else if (w_sel_pend) begin
      w_rd_val[NUM_SOURCES:1] = r_pending;
    end else if (w_sel_en) begin
      w_rd_val[NUM_SOURCES:1] = r_enable;
    end else if (w_sel_thr) begin
      w_rd_val[PRIO_WIDTH-1:0] = r_threshold;
    end else if (w_sel_claim) begin
      w_rd_val[IDW-1:0] = w_best_id;
    end
  end

  // Read data is loaded with the accepted read and cleared in every other cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_rd_data <= '0;
    else if (w_do_rd) r_rd_data <= w_rd_val;
    else              r_rd_data <= '0;
  end

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_sources;
      r_sync2 <= r_sync1;
    end
  end

  // Gateway plus claim/complete; the claim is applied last so it beats a same-edge set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending   <= '0;
      r_in_flight <= '0;
    end else begin
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        if (r_sync2[i] && !r_in_flight[i] && !r_pending[i]) r_pending[i] <= 1'b1;
        if (w_claim && (int'(w_best_id) == i)) begin
          r_pending[i]   <= 1'b0;
          r_in_flight[i] <= 1'b1;
        end else if (w_complete && (int'(w_cid) == i) && r_in_flight[i]) begin
          r_in_flight[i] <= 1'b0;
        end
      end
    end
  end

  // Configuration registers written through the bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NUM_SOURCES; i++) r_prio[i] <= '0;
      r_enable    <= '0;
      r_threshold <= '0;
    end else if (w_do_wr) begin
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        if (w_is_prio && (int'(w_word) == i)) r_prio[i] <= bus_wr_data[PRIO_WIDTH-1:0];
      end
      if (w_sel_en)  r_enable    <= bus_wr_data[NUM_SOURCES:1];
      if (w_sel_thr) r_threshold <= bus_wr_data[PRIO_WIDTH-1:0];
    end
  end

  // MEIP is the arbiter result registered one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_ext <= 1'b0;
    else        r_ext <= (w_best_id != '0);
  end

endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: directed scenarios followed by randomized traffic checked
// against a settled-state reference model of the interrupt controller.
module tb_plic_lite;

  localparam int NS = 8;
  localparam int PW = 3;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic [NS-1:0] irq_sources;
  logic          bus_rd_en;
  logic          bus_wr_en;
  logic [7:0]    bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_ack;
  logic          external_interrupt;

  int n_vec  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model state (indexed by source ID)
  logic [PW-1:0] m_prio [1:NS];
  logic [NS:1]   m_en;
  logic [NS:1]   m_pend;
  logic [NS:1]   m_infl;
  logic [NS:1]   m_lines;
  logic [PW-1:0] m_thr;

  plic_lite #(.NUM_SOURCES(NS), .PRIO_WIDTH(PW), .DATA_SIZE(DW)) dut (
    .clock              (clock),
    .reset              (reset),
    .irq_sources        (irq_sources),
    .bus_rd_en          (bus_rd_en),
    .bus_wr_en          (bus_wr_en),
    .bus_addr           (bus_addr),
    .bus_wr_data        (bus_wr_data),
    .bus_rd_data        (bus_rd_data),
    .bus_ack            (bus_ack),
    .external_interrupt (external_interrupt)
  );

  // Clock
  always #5 clock = ~clock;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n edges; sample/drive 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    bus_rd_en   = 1'b0;
    bus_wr_en   = 1'b0;
    bus_addr    = '0;
    bus_wr_data = '0;
    irq_sources = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [DW-1:0] d);
    bus_addr    = a;
    bus_wr_data = d;
    bus_wr_en   = 1'b1;
    tick(1);
    check("wr_ack", bus_ack, 1);
    bus_wr_en = 1'b0;
    tick(1);
    check("wr_ack_drop", bus_ack, 0);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [DW-1:0] d);
    bus_addr  = a;
    bus_rd_en = 1'b1;
    tick(1);
    check("rd_ack", bus_ack, 1);
    d         = bus_rd_data;
    bus_rd_en = 1'b0;
    tick(1);
    check("rd_ack_drop", bus_ack, 0);
    check("rd_data_idle", bus_rd_data, 0);
  endtask

  // Highest candidate priority first, then the lowest ID holding it.
  function automatic logic [4:0] model_best();
    int top = 0;
    for (int i = 1; i <= NS; i++)
      if (m_pend[i] && m_en[i] && (int'(m_prio[i]) > int'(m_thr)) && (int'(m_prio[i]) > top))
        top = int'(m_prio[i]);
    if (top == 0) return 5'd0;
    for (int i = 1; i <= NS; i++)
      if (m_pend[i] && m_en[i] && (int'(m_prio[i]) == top)) return 5'(i);
    return 5'd0;
  endfunction

  // Lines held long enough are latched unless the source is being serviced.
  task automatic model_settle();
    m_pend = m_pend | (m_lines & ~m_infl);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [4:0]    b;
    int            id;
    int            v;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_ack", bus_ack, 0);
    check("rst_ext", external_interrupt, 0);
    check("rst_rd_data", bus_rd_data, 0);
    bus_read(8'h80, d); check("rst_pending", d, 0);
    bus_read(8'h84, d); check("rst_enable", d, 0);
    bus_read(8'h88, d); check("rst_threshold", d, 0);
    bus_read(8'h0C, d); check("rst_prio3", d, 0);

    // ---------------- basic path ----------------
    bus_write(8'h0C, 2);
    bus_write(8'h84, 32'h08);
    bus_write(8'h88, 0);
    irq_sources = 8'h04;           // sampled at the next edge k
    tick(3);                       // after k+2: pending set, MEIP not yet
    check("basic_ext_early", external_interrupt, 0);
    tick(1);                       // after k+3
    check("basic_ext", external_interrupt, 1);
    bus_read(8'h80, d); check("basic_pending", d, 32'h08);
    bus_read(8'h8C, d); check("basic_claim", d, 3);
    check("basic_ext_clear", external_interrupt, 0);
    bus_read(8'h80, d); check("basic_pending_clear", d, 0);

    // ---------------- complete and re-arm (source 3 in flight, line high) ----
    tick(3);
    bus_read(8'h80, d); check("inflight_pend", d, 0);
    bus_write(8'h8C, 7);
    bus_write(8'h8C, 0);
    tick(3);
    bus_read(8'h80, d); check("bad_complete_pend", d, 0);
    check("bad_complete_ext", external_interrupt, 0);
    bus_write(8'h8C, 3);
    check("rearm_ext_early", external_interrupt, 0);
    tick(1);
    check("rearm_ext", external_interrupt, 1);
    bus_read(8'h80, d); check("rearm_pending", d, 32'h08);

    // ---------------- priority and tie-break ----------------
    do_reset();
    bus_write(8'h08, 5);
    bus_write(8'h14, 5);
    bus_write(8'h18, 7);
    bus_write(8'h84, 32'h64);
    irq_sources = 8'h32;
    tick(5);
    check("tie_ext", external_interrupt, 1);
    exp_q.push_back(6);
    exp_q.push_back(2);
    exp_q.push_back(5);
    exp_q.push_back(0);
    while (exp_q.size() > 0) begin
      bus_read(8'h8C, d);
      check("tie_claim", d, exp_q.pop_front());
    end
    bus_read(8'h80, d); check("tie_pending", d, 0);
    check("tie_ext_idle", external_interrupt, 0);

    // ---------------- threshold masking ----------------
    do_reset();
    bus_write(8'h10, 3);
    bus_write(8'h84, 32'h10);
    bus_write(8'h88, 3);
    irq_sources = 8'h08;
    tick(5);
    check("thr_ext_masked", external_interrupt, 0);
    bus_read(8'h8C, d); check("thr_claim_masked", d, 0);
    bus_write(8'h88, 2);
    check("thr_ext", external_interrupt, 1);
    bus_read(8'h8C, d); check("thr_claim", d, 4);

    // ---------------- bus handshake ----------------
    do_reset();
    bus_write(8'h84, 32'hA7);
    bus_addr  = 8'h84;
    bus_rd_en = 1'b1;
    check("hs_ack_req_cycle", bus_ack, 0);
    tick(1);
    check("hs_ack", bus_ack, 1);
    check("hs_data", bus_rd_data, 32'hA6);
    bus_rd_en = 1'b0;
    tick(1);
    check("hs_ack_low", bus_ack, 0);
    check("hs_data_low", bus_rd_data, 0);
    bus_addr    = 8'h88;
    bus_wr_data = 5;
    bus_rd_en   = 1'b1;
    bus_wr_en   = 1'b1;
    tick(1);
    check("rdwr_ack", bus_ack, 1);
    check("rdwr_data", bus_rd_data, 0);
    bus_rd_en = 1'b0;
    bus_wr_en = 1'b0;
    tick(1);
    bus_read(8'h88, d);  check("rdwr_threshold", d, 5);
    bus_read(8'hF0, d);  check("unmapped_read", d, 0);
    bus_read(8'h87, d);  check("low_addr_bits", d, 32'hA6);
    bus_write(8'h24, 7);
    bus_read(8'h24, d);  check("prio_id9", d, 0);
    bus_write(8'h00, 7);
    bus_read(8'h00, d);  check("prio_id0", d, 0);

    // ---------------- async reset during ACK ----------------
    do_reset();
    bus_write(8'h04, 7);
    bus_write(8'h84, 32'h02);
    bus_write(8'h88, 3);
    irq_sources = 8'h01;
    tick(5);
    check("ar_ext_before", external_interrupt, 1);
    bus_addr  = 8'h88;
    bus_rd_en = 1'b1;
    tick(1);
    check("ar_ack_before", bus_ack, 1);
    check("ar_data_before", bus_rd_data, 3);
    #2;
    reset = 1'b0;
    #1;
    check("ar_ack", bus_ack, 0);
    check("ar_data", bus_rd_data, 0);
    check("ar_ext", external_interrupt, 0);
    bus_rd_en   = 1'b0;
    irq_sources = '0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("ar_no_ack", bus_ack, 0);
    end
    bus_read(8'h88, d); check("ar_threshold", d, 0);
    bus_read(8'h84, d); check("ar_enable", d, 0);
    bus_read(8'h04, d); check("ar_prio1", d, 0);
    bus_read(8'h80, d); check("ar_pending", d, 0);
    check("ar_ext_after", external_interrupt, 0);

    // ---------------- randomized traffic vs reference model ----------------
    do_reset();
    m_en = '0; m_pend = '0; m_infl = '0; m_lines = '0; m_thr = '0;
    for (int i = 1; i <= NS; i++) begin
      m_prio[i] = PW'($urandom_range(1, 7));
      bus_write(8'(i * 4), DW'(m_prio[i]));
    end
    v = $urandom_range(0, 511);
    bus_write(8'h84, DW'(v));
    m_en = NS'(v >> 1);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          id = $urandom_range(0, 12);
          v  = $urandom_range(0, 7);
          bus_write(8'(id * 4), DW'(v));
          if (id >= 1 && id <= NS) m_prio[id] = PW'(v);
        end
        1: begin
          v = $urandom_range(0, 511);
          bus_write(8'h84, DW'(v));
          m_en = NS'(v >> 1);
        end
        2: begin
          v = $urandom_range(0, 3);
          bus_write(8'h88, DW'(v));
          m_thr = PW'(v);
        end
        default: tick(1);
      endcase
      tick(3);
      model_settle();
      m_lines     = NS'($urandom_range(0, 255));
      irq_sources = m_lines;
      tick(5);
      model_settle();
      b = model_best();
      check("rnd_ext", external_interrupt, (b != 0));
      bus_read(8'h80, d); check("rnd_pending", d, {m_pend, 1'b0});
      bus_read(8'h8C, d); check("rnd_claim", d, b);
      if (b != 0) begin
        m_pend[b] = 1'b0;
        m_infl[b] = 1'b1;
      end
      id = $urandom_range(0, 10);
      bus_write(8'h8C, DW'(id));
      if (id >= 1 && id <= NS && m_infl[id]) m_infl[id] = 1'b0;
    end

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
